fpu_result_checker: RTL
=======================

Name: fpu_result_checker

Overview:
- Synthesizable self-check block that sits on the FPU output side.
- The operand issuer pushes the expected IEEE-754 single-precision result into an internal FIFO at issue time. The FPU result stream pops and compares against it.
- Each result is classified as exact match, rounding error (±1 ULP, i.e. raw 32-bit difference of ±1), or mismatch. Saturating tallies and first-mismatch capture registers are readable by a host or by on-chip debug logic.

Parameters:
- DEPTH, 8, expected-value FIFO depth in entries; power of two, ≥2.
- CNT_W, 32, width of each classification counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ExpValid  input  1  expected value present on ExpData.
- ExpData  input  32  expected result bits.
- ExpReady  output  1  FIFO not full; a push occurs when ExpValid && ExpReady.
- ResValid  input  1  FPU result present on ResData, one-cycle strobe per result.
- ResData  input  32  FPU result bits.
- Clear  input  1  synchronous clear of counters and sticky/capture state.
- NumMatch  output  CNT_W  count of exact matches.
- NumRound  output  CNT_W  count of ±1 raw-difference results.
- NumMismatch  output  CNT_W  count of all other results.
- Pending  output  $clog2(DEPTH)+1  current FIFO occupancy.
- Underflow  output  1  sticky: a result arrived with the FIFO empty.
- Overflow  output  1  sticky: ExpValid asserted while FIFO full (value dropped).
- FirstMisValid  output  1  sticky: first-mismatch registers hold data.
- FirstMisRes  output  32  ResData of the first mismatch.
- FirstMisExp  output  32  expected value of the first mismatch.

Behaviour:
- Reset (RST_N low, asynchronous): FIFO empty, Pending=0, ExpReady=1, all counters 0, Underflow/Overflow/FirstMisValid 0, FirstMisRes/FirstMisExp 0. ExpReady must be 1 within the reset state itself.
- FIFO:
  - Circular buffer with read/write pointers that wrap at DEPTH, plus an occupancy counter.
  - ExpReady = (Pending != DEPTH), registered-state derived with no combinational path from ExpValid.
  - A push writes ExpData at the write pointer. A pop reads at the read pointer.
- Compare, issued when ResValid=1 and Pending>0:
  - Pop the head and compute diff = (ResData - head) mod 2^32.
  - diff==0: NumMatch+1. diff==1 or diff==32'hFFFFFFFF: NumRound+1. Otherwise NumMismatch+1.
  - Counter update is visible the cycle after the ResValid edge (1-cycle latency). Comparison is unregistered within the cycle; head is read combinationally.
- Mismatch capture: on a mismatch with FirstMisValid=0, load FirstMisRes/FirstMisExp and set FirstMisValid. Later mismatches do not overwrite.
- ResValid with Pending==0: no counter change, Underflow set, no pop.
- ExpValid with Pending==DEPTH and no pop that cycle: data dropped, Overflow set.
- Push and pop in the same cycle with Pending in 1..DEPTH-1: both occur, Pending unchanged.
- Push and pop in the same cycle with Pending==DEPTH: pop occurs, push refused because ExpReady=0, Overflow set.
- Push and pop in the same cycle with Pending==0: underflow; the incoming value is stored, never bypassed, Pending becomes 1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Clear=1: next edge zeroes counters, Underflow, Overflow, FirstMisValid and capture registers. FIFO contents and pointers are kept.
- Clear takes priority over a same-cycle increment: the counter reads 0 afterwards and the event is lost.
- Reset asserted mid-stream discards FIFO contents and all state immediately.
- Results are compared strictly in push order. No tagging or reordering.

Test Plan:
- Reset, then push 3F800000 and apply result 3F800000 → next cycle NumMatch=1, Pending=0, others 0.
- Push 40490FDB and apply result 40490FDC; push 40490FDB and apply result 40490FDA → NumRound=2, NumMismatch=0.
- Push 3F800000,40000000; results 3F800001? no — results BF800000 then 7FC00000 → NumMismatch=2, FirstMisRes=BF800000, FirstMisExp=3F800000, FirstMisValid=1.
- Fill FIFO with 8 pushes → ExpReady=0, Pending=8. A 9th push sets Overflow. Drain with 8 matching results → all match, Pending=0, pointers wrapped correctly on a second fill/drain pass.
- ResValid with empty FIFO and simultaneous ExpValid=1 → Underflow=1, counters unchanged, Pending=1. A later matching result gives NumMatch=1.
- Preload NumMatch to saturation (CNT_W=4 instance, 16 matches) → stays at 15. Pulse Clear alongside a match → all counters 0 and stickies 0; FIFO occupancy preserved. Assert RST_N=0 mid-stream → outputs reset immediately, asynchronously.

Source files
------------

// File: rtl/fpu_result_checker.sv
// Self-check block for the FPU output stream: expected results are queued at issue
// time, then each FPU result is classified against the oldest queued value.
module fpu_result_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     ExpValid,
    input  logic [31:0]              ExpData,
    output logic                     ExpReady,
    input  logic                     ResValid,
    input  logic [31:0]              ResData,
    input  logic                     Clear,
    output logic [CNT_W-1:0]         NumMatch,
    output logic [CNT_W-1:0]         NumRound,
    output logic [CNT_W-1:0]         NumMismatch,
    output logic [$clog2(DEPTH):0]   Pending,
    output logic                     Underflow,
    output logic                     Overflow,
    output logic                     FirstMisValid,
    output logic [31:0]              FirstMisRes,
    output logic [31:0]              FirstMisExp
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LP_FULL = PW'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [PW-1:0]    r_count;
    logic [CNT_W-1:0] r_num_match;
    logic [CNT_W-1:0] r_num_round;
    logic [CNT_W-1:0] r_num_mis;
    logic             r_underflow;
    logic             r_overflow;
    logic             r_fmv;
    logic [31:0]      r_fm_res;
    logic [31:0]      r_fm_exp;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head;
    logic [31:0]      w_diff;
    logic             w_is_match;
    logic             w_is_round;
    logic             w_is_mis;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Readiness depends only on registered occupancy, so a pop in the same cycle
    // never frees a slot for a simultaneous push.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == LP_FULL);
    assign w_push   = ExpValid && !w_full;
    assign w_pop    = ResValid && !w_empty;
    assign w_head   = r_mem[r_rptr];
    assign w_diff   = ResData - w_head;

    assign w_is_match = w_pop && (w_diff == 32'h0000_0000);
    assign w_is_round = w_pop && ((w_diff == 32'h0000_0001) || (w_diff == 32'hFFFF_FFFF));
    assign w_is_mis   = w_pop && !w_is_match && !w_is_round;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= ExpData;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over any same-cycle event; the FIFO itself is untouched by it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_num_match <= '0;
            r_num_round <= '0;
            r_num_mis   <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_fmv       <= 1'b0;
            r_fm_res    <= '0;
            r_fm_exp    <= '0;
        end else if (Clear) begin
            r_num_match <= '0;
            r_num_round <= '0;
            r_num_mis   <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_fmv       <= 1'b0;
            r_fm_res    <= '0;
            r_fm_exp    <= '0;
        end else begin
            if (w_is_match) r_num_match <= sat_inc(r_num_match);
            if (w_is_round) r_num_round <= sat_inc(r_num_round);
            if (w_is_mis)   r_num_mis   <= sat_inc(r_num_mis);
            if (ResValid && w_empty) r_underflow <= 1'b1;
            if (ExpValid && w_full)  r_overflow  <= 1'b1;
            if (w_is_mis && !r_fmv) begin
                r_fmv    <= 1'b1;
                r_fm_res <= ResData;
                r_fm_exp <= w_head;
            end
        end
    end

    assign ExpReady      = !w_full;
    assign Pending       = r_count;
    assign NumMatch      = r_num_match;
    assign NumRound      = r_num_round;
    assign NumMismatch   = r_num_mis;
    assign Underflow     = r_underflow;
    assign Overflow      = r_overflow;
    assign FirstMisValid = r_fmv;
    assign FirstMisRes   = r_fm_res;
    assign FirstMisExp   = r_fm_exp;

endmodule
